// File: rtl/eth_ptp_frame_gen_pkg.sv
// Shared types and constants for the PTP-stamped Ethernet frame generator:
// FSM state encoding, payload pattern codes and the pattern byte helper.
package eth_ptp_frame_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_GAP     = 2'd3
    } state_e;

    localparam logic [1:0] PAT_INC   = 2'd0;
    localparam logic [1:0] PAT_DEC   = 2'd1;
    localparam logic [1:0] PAT_CONST = 2'd2;

    localparam int MAC_W    = 48;
    localparam int TYPE_W   = 16;
    localparam int TS_W     = 96;
    localparam int TS_BYTES = 12;

    // Pattern byte for payload index k (mod 256); code 3 behaves as increment.
    function automatic logic [7:0] pattern_byte(input logic [1:0] pat,
                                                input logic [7:0] seed,
                                                input logic [7:0] k8);
        logic [7:0] b;
        case (pat)
            PAT_DEC:   b = seed - k8;
            PAT_CONST: b = seed;
            default:   b = seed + k8;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/eth_ptp_frame_gen_if.sv
// Ethernet header + 8-bit payload stream bundle between the frame generator
// (master) and eth_axis_tx (slave).
interface eth_ptp_frame_gen_if;
    import eth_ptp_frame_gen_pkg::*;

    logic              m_eth_hdr_valid;
    logic              m_eth_hdr_ready;
    logic [MAC_W-1:0]  m_eth_dest_mac;
    logic [MAC_W-1:0]  m_eth_src_mac;
    logic [TYPE_W-1:0] m_eth_type;
    logic [7:0]        m_eth_payload_axis_tdata;
    logic              m_eth_payload_axis_tkeep;
    logic              m_eth_payload_axis_tvalid;
    logic              m_eth_payload_axis_tready;
    logic              m_eth_payload_axis_tlast;
    logic              m_eth_payload_axis_tuser;

    modport master (
        output m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
        output m_eth_payload_axis_tdata, m_eth_payload_axis_tkeep,
        output m_eth_payload_axis_tvalid, m_eth_payload_axis_tlast,
        output m_eth_payload_axis_tuser,
        input  m_eth_hdr_ready, m_eth_payload_axis_tready
    );

    modport slave (
        input  m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
        input  m_eth_payload_axis_tdata, m_eth_payload_axis_tkeep,
        input  m_eth_payload_axis_tvalid, m_eth_payload_axis_tlast,
        input  m_eth_payload_axis_tuser,
        output m_eth_hdr_ready, m_eth_payload_axis_tready
    );

endinterface

// File: rtl/eth_ptp_frame_gen_pattern.sv
// Stateless payload byte selector: timestamp bytes (MSB first) for the first
// twelve indices when enabled, otherwise the configured pattern.
module eth_ptp_frame_gen_pattern
    import eth_ptp_frame_gen_pkg::*;
#(
    parameter int LEN_WIDTH = 16,
    parameter int TS_ENABLE = 1
) (
    input  logic [LEN_WIDTH-1:0] k,
    input  logic [7:0]           seed,
    input  logic [1:0]           pattern,
    input  logic [TS_W-1:0]      ts,
    output logic [7:0]           data_o
);

    logic [6:0] ts_lsb_s;

    // Byte k of the timestamp starts at bit 88-8k; only used while k < 12.
    always_comb begin
        ts_lsb_s = 7'd88 - {k[3:0], 3'b000};
        if ((TS_ENABLE != 0) && (k < LEN_WIDTH'(TS_BYTES))) begin
            data_o = ts[ts_lsb_s +: 8];
        end else begin
            data_o = pattern_byte(pattern, seed, k[7:0]);
        end
    end

endmodule

// File: rtl/eth_ptp_frame_gen.sv
// Burst Ethernet frame source for eth_axis_tx: header handshake, payload with
// an optional embedded PTP timestamp, programmable inter-frame gap.
module eth_ptp_frame_gen
    import eth_ptp_frame_gen_pkg::*;
#(
    parameter int LEN_WIDTH = 16,
    parameter int GAP_WIDTH = 32,
    parameter int TS_ENABLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  start,
    input  logic [MAC_W-1:0]      cfg_dest_mac,
    input  logic [MAC_W-1:0]      cfg_src_mac,
    input  logic [TYPE_W-1:0]     cfg_eth_type,
    input  logic [LEN_WIDTH-1:0]  cfg_payload_len,
    input  logic [15:0]           cfg_frame_count,
    input  logic [GAP_WIDTH-1:0]  cfg_gap_cycles,
    input  logic [1:0]            cfg_pattern,
    input  logic [7:0]            cfg_seed,
    input  logic                  cfg_bad_frame,
    input  logic [TS_W-1:0]       ptp_ts_96,
    eth_ptp_frame_gen_if.master   m,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           frames_sent,
    output logic [TS_W-1:0]       ts_out,
    output logic                  ts_out_valid
);

    state_e               state_q, state_d;
    logic [MAC_W-1:0]     dest_q, dest_d, src_q, src_d;
    logic [TYPE_W-1:0]    type_q, type_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, k_q, k_d;
    logic [15:0]          count_q, count_d, burst_q, burst_d;
    logic [GAP_WIDTH-1:0] gap_cfg_q, gap_cfg_d, gap_cnt_q, gap_cnt_d;
    logic [1:0]           pat_q, pat_d;
    logic [7:0]           seed_q, seed_d, tdata_q, tdata_d;
    logic                 bad_q, bad_d;
    logic                 hdr_valid_q, hdr_valid_d, tvalid_q, tvalid_d;
    logic                 tlast_q, tlast_d, tuser_q, tuser_d;
    logic                 busy_q, busy_d, done_q, done_d, ts_valid_q, ts_valid_d;
    logic [31:0]          frames_q, frames_d;
    logic [TS_W-1:0]      ts_q, ts_d;

    logic       launch_s, hdr_hs_s, pay_hs_s, last_hs_s, burst_end_s;
    logic [7:0] pat_byte_s;

    assign launch_s    = (state_q == ST_IDLE) && start && enable;
    assign hdr_hs_s    = hdr_valid_q && m.m_eth_hdr_ready;
    assign pay_hs_s    = tvalid_q && m.m_eth_payload_axis_tready;
    assign last_hs_s   = pay_hs_s && tlast_q;
    // A zero frame count means run until enable drops.
    assign burst_end_s = !enable || ((count_q != 16'd0) && ((burst_q + 16'd1) == count_q));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; enable is only looked at between frames.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (launch_s) state_d = ST_HDR;
                else          state_d = ST_IDLE;
            end
            ST_HDR: begin
                if (hdr_hs_s) state_d = ST_PAYLOAD;
                else          state_d = ST_HDR;
            end
            ST_PAYLOAD: begin
                if (!last_hs_s)                        state_d = ST_PAYLOAD;
                else if (burst_end_s)                  state_d = ST_IDLE;
                else if (gap_cfg_q != GAP_WIDTH'(0))   state_d = ST_GAP;
                else                                   state_d = ST_HDR;
            end
            ST_GAP: begin
                if (!enable)                           state_d = ST_IDLE;
                else if (gap_cnt_q == GAP_WIDTH'(0))   state_d = ST_HDR;
                else                                   state_d = ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadow configuration, counters and the timestamp snapshot.
    always_comb begin
        dest_d    = launch_s ? cfg_dest_mac    : dest_q;
        src_d     = launch_s ? cfg_src_mac     : src_q;
        type_d    = launch_s ? cfg_eth_type    : type_q;
        count_d   = launch_s ? cfg_frame_count : count_q;
        gap_cfg_d = launch_s ? cfg_gap_cycles  : gap_cfg_q;
        pat_d     = launch_s ? cfg_pattern     : pat_q;
        seed_d    = launch_s ? cfg_seed        : seed_q;
        bad_d     = launch_s ? cfg_bad_frame   : bad_q;
        if (launch_s) begin
            len_d = (cfg_payload_len == LEN_WIDTH'(0)) ? LEN_WIDTH'(1) : cfg_payload_len;
        end else begin
            len_d = len_q;
        end
        if (hdr_hs_s)      k_d = LEN_WIDTH'(0);
        else if (pay_hs_s) k_d = k_q + LEN_WIDTH'(1);
        else               k_d = k_q;
        if (launch_s)       burst_d = 16'd0;
        else if (last_hs_s) burst_d = burst_q + 16'd1;
        else                burst_d = burst_q;
        if (last_hs_s) begin
            gap_cnt_d = gap_cfg_q - GAP_WIDTH'(1);
        end else if ((state_q == ST_GAP) && (gap_cnt_q != GAP_WIDTH'(0))) begin
            gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end else begin
            gap_cnt_d = gap_cnt_q;
        end
        frames_d   = last_hs_s ? (frames_q + 32'd1) : frames_q;
        ts_d       = hdr_hs_s ? ptp_ts_96 : ts_q;
        ts_valid_d = hdr_hs_s;
    end

    eth_ptp_frame_gen_pattern #(
        .LEN_WIDTH (LEN_WIDTH),
        .TS_ENABLE (TS_ENABLE)
    ) u_pattern (
        .k       (k_d),
        .seed    (seed_q),
        .pattern (pat_q),
        .ts      (ts_d),
        .data_o  (pat_byte_s)
    );

    // Output decode from the next state so every port comes straight from a flop.
    always_comb begin
        hdr_valid_d = (state_d == ST_HDR);
        tvalid_d    = (state_d == ST_PAYLOAD);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (last_hs_s && burst_end_s) || ((state_q == ST_GAP) && !enable);
        if (tvalid_d) begin
            tdata_d = pat_byte_s;
            tlast_d = (k_d == (len_q - LEN_WIDTH'(1)));
        end else begin
            tdata_d = 8'd0;
            tlast_d = 1'b0;
        end
        tuser_d = tlast_d && bad_q;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dest_q      <= {MAC_W{1'b0}};
            src_q       <= {MAC_W{1'b0}};
            type_q      <= {TYPE_W{1'b0}};
            len_q       <= LEN_WIDTH'(0);
            k_q         <= LEN_WIDTH'(0);
            count_q     <= 16'd0;
            burst_q     <= 16'd0;
            gap_cfg_q   <= GAP_WIDTH'(0);
            gap_cnt_q   <= GAP_WIDTH'(0);
            pat_q       <= 2'd0;
            seed_q      <= 8'd0;
            bad_q       <= 1'b0;
            hdr_valid_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= 8'd0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frames_q    <= 32'd0;
            ts_q        <= {TS_W{1'b0}};
            ts_valid_q  <= 1'b0;
        end else begin
            dest_q      <= dest_d;
            src_q       <= src_d;
            type_q      <= type_d;
            len_q       <= len_d;
            k_q         <= k_d;
            count_q     <= count_d;
            burst_q     <= burst_d;
            gap_cfg_q   <= gap_cfg_d;
            gap_cnt_q   <= gap_cnt_d;
            pat_q       <= pat_d;
            seed_q      <= seed_d;
            bad_q       <= bad_d;
            hdr_valid_q <= hdr_valid_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frames_q    <= frames_d;
            ts_q        <= ts_d;
            ts_valid_q  <= ts_valid_d;
        end
    end

    assign m.m_eth_hdr_valid           = hdr_valid_q;
    assign m.m_eth_dest_mac            = dest_q;
    assign m.m_eth_src_mac             = src_q;
    assign m.m_eth_type                = type_q;
    assign m.m_eth_payload_axis_tdata  = tdata_q;
    assign m.m_eth_payload_axis_tkeep  = 1'b1;
    assign m.m_eth_payload_axis_tvalid = tvalid_q;
    assign m.m_eth_payload_axis_tlast  = tlast_q;
    assign m.m_eth_payload_axis_tuser  = tuser_q;
    assign busy                        = busy_q;
    assign done                        = done_q;
    assign frames_sent                 = frames_q;
    assign ts_out                      = ts_q;
    assign ts_out_valid                = ts_valid_q;

endmodule

// File: tb/tb_eth_ptp_frame_gen.sv
// Directed bench for eth_ptp_frame_gen: one instance without and one with the
// embedded timestamp, driven identically.
module tb_eth_ptp_frame_gen;
    import eth_ptp_frame_gen_pkg::*;

    localparam logic [95:0] TS_A = 96'hA1B2C3D4_E5F60718_293A4B5C;
    localparam logic [95:0] TS_B = 96'h0F1E2D3C_4B5A6978_8796A5B4;
    localparam logic [95:0] TS_C = 96'h11111111_22222222_33333333;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic        rst, enable, start, cfg_bad_frame, stall_en, rnd_h, rnd_t;
    logic [47:0] cfg_dest_mac, cfg_src_mac;
    logic [15:0] cfg_eth_type, cfg_payload_len, cfg_frame_count;
    logic [31:0] cfg_gap_cycles;
    logic [1:0]  cfg_pattern;
    logic [7:0]  cfg_seed;
    logic [95:0] ptp_ts_96;

    logic        busy0, done0, tsv0, busy1, done1, tsv1;
    logic [31:0] frames0, frames1;
    logic [95:0] ts_out0, ts_out1;

    eth_ptp_frame_gen_if if0 ();
    eth_ptp_frame_gen_if if1 ();

    assign if0.m_eth_hdr_ready           = stall_en ? rnd_h : 1'b1;
    assign if1.m_eth_hdr_ready           = stall_en ? rnd_h : 1'b1;
    assign if0.m_eth_payload_axis_tready = stall_en ? rnd_t : 1'b1;
    assign if1.m_eth_payload_axis_tready = stall_en ? rnd_t : 1'b1;

    eth_ptp_frame_gen #(.LEN_WIDTH(16), .GAP_WIDTH(32), .TS_ENABLE(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .start(start),
        .cfg_dest_mac(cfg_dest_mac), .cfg_src_mac(cfg_src_mac), .cfg_eth_type(cfg_eth_type),
        .cfg_payload_len(cfg_payload_len), .cfg_frame_count(cfg_frame_count),
        .cfg_gap_cycles(cfg_gap_cycles), .cfg_pattern(cfg_pattern), .cfg_seed(cfg_seed),
        .cfg_bad_frame(cfg_bad_frame), .ptp_ts_96(ptp_ts_96), .m(if0.master),
        .busy(busy0), .done(done0), .frames_sent(frames0), .ts_out(ts_out0), .ts_out_valid(tsv0));

    eth_ptp_frame_gen #(.LEN_WIDTH(16), .GAP_WIDTH(32), .TS_ENABLE(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .start(start),
        .cfg_dest_mac(cfg_dest_mac), .cfg_src_mac(cfg_src_mac), .cfg_eth_type(cfg_eth_type),
        .cfg_payload_len(cfg_payload_len), .cfg_frame_count(cfg_frame_count),
        .cfg_gap_cycles(cfg_gap_cycles), .cfg_pattern(cfg_pattern), .cfg_seed(cfg_seed),
        .cfg_bad_frame(cfg_bad_frame), .ptp_ts_96(ptp_ts_96), .m(if1.master),
        .busy(busy1), .done(done1), .frames_sent(frames1), .ts_out(ts_out1), .ts_out_valid(tsv1));

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: captured beats, gap lengths, pulse counts and stall stability.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       ql[$];
    logic       qu[$];
    int         gaps[$];
    int         cyc = 0, last_cyc = 0, done_cnt = 0, tsv_cnt = 0;
    bit         have_last = 1'b0;
    logic       p_hv = 1'b0, p_hr = 1'b0, p_tv = 1'b0, p_tr = 1'b0, p_tl = 1'b0;
    logic [7:0] p_td = 8'd0;
    logic [47:0] p_dm = 48'd0;

    always @(negedge clk) begin
        rnd_h = 1'($urandom_range(0, 1));
        rnd_t = 1'($urandom_range(0, 1));
    end

    always @(posedge clk) begin
        cyc++;
        if (if0.m_eth_payload_axis_tvalid && if0.m_eth_payload_axis_tready)
            q0.push_back(if0.m_eth_payload_axis_tdata);
        if (if1.m_eth_payload_axis_tvalid && if1.m_eth_payload_axis_tready) begin
            q1.push_back(if1.m_eth_payload_axis_tdata);
            ql.push_back(if1.m_eth_payload_axis_tlast);
            qu.push_back(if1.m_eth_payload_axis_tuser);
            if (if1.m_eth_payload_axis_tlast) begin
                last_cyc  = cyc;
                have_last = 1'b1;
            end
        end
        if (if1.m_eth_hdr_valid && !p_hv && have_last) gaps.push_back(cyc - last_cyc - 1);
        if (done1) done_cnt++;
        if (tsv1) tsv_cnt++;
        if (stall_en && p_tv && !p_tr) begin
            chk("hold_tvalid", if1.m_eth_payload_axis_tvalid, 1'b1);
            chk("hold_tdata", if1.m_eth_payload_axis_tdata, p_td);
            chk("hold_tlast", if1.m_eth_payload_axis_tlast, p_tl);
        end
        if (stall_en && p_hv && !p_hr) begin
            chk("hold_hdr_valid", if1.m_eth_hdr_valid, 1'b1);
            chk("hold_dest_mac", if1.m_eth_dest_mac, p_dm);
        end
        p_hv = if1.m_eth_hdr_valid;
        p_hr = if1.m_eth_hdr_ready;
        p_tv = if1.m_eth_payload_axis_tvalid;
        p_tr = if1.m_eth_payload_axis_tready;
        p_tl = if1.m_eth_payload_axis_tlast;
        p_td = if1.m_eth_payload_axis_tdata;
        p_dm = if1.m_eth_dest_mac;
    end

    task automatic clear_mon();
        q0.delete(); q1.delete(); ql.delete(); qu.delete(); gaps.delete();
        have_last = 1'b0;
        done_cnt  = 0;
        tsv_cnt   = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_seen"}, (done_cnt != 0), 1'b1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic set_cfg(input logic [15:0] len, input logic [15:0] cnt, input logic [31:0] gap,
                           input logic [1:0] pat, input logic [7:0] seed, input logic bad);
        cfg_payload_len = len;
        cfg_frame_count = cnt;
        cfg_gap_cycles  = gap;
        cfg_pattern     = pat;
        cfg_seed        = seed;
        cfg_bad_frame   = bad;
    endtask

    function automatic logic [7:0] ts_byte(input logic [95:0] ts, input int j);
        return ts[95 - 8 * j -: 8];
    endfunction

    typedef struct {
        logic [15:0] len;
        logic [1:0]  pat;
        logic [7:0]  seed;
        logic        bad;
        int          n;
        logic [7:0]  first0;
        logic [7:0]  last0;
        logic [7:0]  last1;
        logic        usr;
    } vec_t;

    vec_t vt[7];

    initial begin
        int   base, nl, nu, bad_bytes, n;
        logic [7:0] expb;

        vt[0] = '{16'd64, PAT_INC,   8'h00, 1'b0, 64, 8'h00, 8'h3F, 8'h3F, 1'b0};
        vt[1] = '{16'd22, PAT_DEC,   8'd120, 1'b0, 22, 8'h78, 8'h63, 8'h63, 1'b0};
        vt[2] = '{16'd5,  PAT_CONST, 8'h5A, 1'b1, 5,  8'h5A, 8'h5A, 8'hE5, 1'b1};
        vt[3] = '{16'd0,  2'd3,      8'hFE, 1'b1, 1,  8'hFE, 8'hFE, 8'hA1, 1'b1};
        vt[4] = '{16'd14, PAT_INC,   8'hFA, 1'b0, 14, 8'hFA, 8'h07, 8'h07, 1'b0};
        vt[5] = '{16'd12, PAT_DEC,   8'h05, 1'b0, 12, 8'h05, 8'hFA, 8'h5C, 1'b0};
        vt[6] = '{16'd13, PAT_DEC,   8'h05, 1'b0, 13, 8'h05, 8'hF9, 8'hF9, 1'b0};

        rst = 1'b1; enable = 1'b1; start = 1'b0; stall_en = 1'b0;
        cfg_dest_mac = 48'h0A0B0C0D0E0F; cfg_src_mac = 48'h020000000001; cfg_eth_type = 16'h88F7;
        set_cfg(16'd0, 16'd1, 32'd0, PAT_INC, 8'd0, 1'b0);
        ptp_ts_96 = TS_A;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outs", {if1.m_eth_hdr_valid, if1.m_eth_payload_axis_tvalid,
                           if1.m_eth_payload_axis_tdata, if1.m_eth_payload_axis_tlast,
                           if1.m_eth_payload_axis_tuser, busy1, done1, tsv1, if1.m_eth_dest_mac}, '0);
        chk("reset_frames", frames1, 32'd0);
        chk("reset_ts_out", ts_out1, 96'd0);
        chk("tkeep", if1.m_eth_payload_axis_tkeep, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Single-frame vectors
        for (int i = 0; i < 7; i++) begin
            set_cfg(vt[i].len, 16'd1, 32'd0, vt[i].pat, vt[i].seed, vt[i].bad);
            base = frames1;
            clear_mon();
            pulse_start();
            wait_done(500, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_n0", i), q0.size(), vt[i].n);
            chk($sformatf("vec%0d_n1", i), q1.size(), vt[i].n);
            if (q0.size() == vt[i].n && q1.size() == vt[i].n) begin
                chk($sformatf("vec%0d_first0", i), q0[0], vt[i].first0);
                chk($sformatf("vec%0d_last0", i), q0[vt[i].n - 1], vt[i].last0);
                chk($sformatf("vec%0d_last1", i), q1[vt[i].n - 1], vt[i].last1);
                chk($sformatf("vec%0d_tlast_end", i), ql[vt[i].n - 1], 1'b1);
                nl = 0; nu = 0;
                for (int j = 0; j < vt[i].n; j++) begin
                    nl += int'(ql[j]);
                    nu += int'(qu[j]);
                end
                chk($sformatf("vec%0d_tlast_cnt", i), nl, 1);
                chk($sformatf("vec%0d_tuser_cnt", i), nu, int'(vt[i].usr));
                if (i == 0) begin
                    for (int j = 0; j < 64; j++) chk("t1_byte", q0[j], j[7:0]);
                end
            end
            chk($sformatf("vec%0d_frames", i), frames1 - base, 1);
            chk($sformatf("vec%0d_done_cnt", i), done_cnt, 1);
            chk($sformatf("vec%0d_busy", i), busy1, 1'b0);
            chk($sformatf("vec%0d_tsv_cnt", i), tsv_cnt, 1);
            chk($sformatf("vec%0d_ts_out", i), ts_out1, TS_A);
        end

        // Timestamp latched at header handshake; cfg changes after start ignored
        set_cfg(16'd22, 16'd1, 32'd0, PAT_DEC, 8'd120, 1'b0);
        ptp_ts_96 = TS_B;
        clear_mon();
        pulse_start();
        cfg_dest_mac = 48'hFFFFFFFFFFFF;
        cfg_payload_len = 16'd3;
        chk("t2_hdr_valid", if1.m_eth_hdr_valid, 1'b1);
        chk("t2_dest_mac", if1.m_eth_dest_mac, 48'h0A0B0C0D0E0F);
        chk("t2_eth_type", if1.m_eth_type, 16'h88F7);
        @(negedge clk);
        ptp_ts_96 = TS_C;
        chk("t2_tvalid_first", if1.m_eth_payload_axis_tvalid, 1'b1);
        wait_done(500, "t2");
        chk("t2_ts_out", ts_out1, TS_B);
        chk("t2_n1", q1.size(), 22);
        if (q1.size() == 22) begin
            for (int j = 0; j < 12; j++) begin
                chk("t2_ts_byte", q1[j], ts_byte(TS_B, j));
                chk("t2_ts_vs_out", q1[j], ts_byte(ts_out1, j));
            end
            for (int j = 0; j < 10; j++) chk("t2_pat_byte", q1[12 + j], 8'(108 - j));
        end
        cfg_dest_mac = 48'h0A0B0C0D0E0F;
        ptp_ts_96 = TS_A;

        // Three frames with a 10-cycle gap
        set_cfg(16'd4, 16'd3, 32'd10, PAT_INC, 8'd0, 1'b0);
        base = frames1;
        clear_mon();
        pulse_start();
        wait_done(300, "t3");
        chk("t3_frames", frames1 - base, 3);
        chk("t3_bytes", q0.size(), 12);
        chk("t3_gap_cnt", gaps.size(), 2);
        if (gaps.size() == 2) begin
            chk("t3_gap0", gaps[0], 10);
            chk("t3_gap1", gaps[1], 10);
        end
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_tsv_cnt", tsv_cnt, 3);

        // Random stalls, two back-to-back 100-byte frames
        set_cfg(16'd100, 16'd2, 32'd0, PAT_INC, 8'h10, 1'b0);
        base = frames1;
        clear_mon();
        stall_en = 1'b1;
        pulse_start();
        wait_done(3000, "t4");
        stall_en = 1'b0;
        chk("t4_frames", frames1 - base, 2);
        chk("t4_n0", q0.size(), 200);
        chk("t4_n1", q1.size(), 200);
        if (q0.size() == 200 && q1.size() == 200) begin
            bad_bytes = 0;
            for (int j = 0; j < 200; j++) begin
                expb = 8'h10 + 8'(j % 100);
                if (q0[j] !== expb) bad_bytes++;
                if ((j % 100) >= 12 && q1[j] !== expb) bad_bytes++;
                if (ql[j] !== ((j % 100) == 99)) bad_bytes++;
            end
            chk("t4_stream_errors", bad_bytes, 0);
        end
        chk("t4_gap_zero_cnt", gaps.size(), 1);
        if (gaps.size() == 1) chk("t4_gap_zero", gaps[0], 0);

        // Continuous burst stopped by enable mid-payload; start while busy ignored
        set_cfg(16'd4, 16'd0, 32'd2, PAT_INC, 8'd0, 1'b0);
        base = frames1;
        clear_mon();
        pulse_start();
        n = 0;
        while ((frames1 - base) < 2 && n < 200) begin @(negedge clk); n++; end
        chk("t5_running", (frames1 - base) >= 2, 1'b1);
        cfg_payload_len = 16'd9;
        pulse_start();
        n = 0;
        while (!(if1.m_eth_payload_axis_tvalid && !if1.m_eth_payload_axis_tlast) && n < 200) begin
            @(negedge clk); n++;
        end
        chk("t5_in_payload", if1.m_eth_payload_axis_tvalid, 1'b1);
        enable = 1'b0;
        wait_done(200, "t5");
        chk("t5_whole_frames", q0.size(), 4 * (frames1 - base));
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_busy", busy1, 1'b0);
        if (ql.size() > 0) chk("t5_tlast_end", ql[ql.size() - 1], 1'b1);
        repeat (5) @(negedge clk);
        chk("t5_no_restart", {busy1, if1.m_eth_hdr_valid}, 2'b00);

        // Enable dropped during the gap
        enable = 1'b1;
        set_cfg(16'd4, 16'd0, 32'd20, PAT_INC, 8'd0, 1'b0);
        base = frames1;
        clear_mon();
        pulse_start();
        n = 0;
        while (!(busy1 && !if1.m_eth_hdr_valid && !if1.m_eth_payload_axis_tvalid) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("t5b_in_gap", busy1, 1'b1);
        enable = 1'b0;
        @(negedge clk);
        chk("t5b_busy", busy1, 1'b0);
        chk("t5b_done", done1, 1'b1);
        chk("t5b_frames", frames1 - base, 1);
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // Reset mid-payload, then a one-byte bad frame
        set_cfg(16'd50, 16'd1, 32'd0, PAT_INC, 8'd0, 1'b0);
        clear_mon();
        pulse_start();
        repeat (4) @(negedge clk);
        chk("t6_mid_frame", if1.m_eth_payload_axis_tvalid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_outs", {if1.m_eth_hdr_valid, if1.m_eth_payload_axis_tvalid,
                            if1.m_eth_payload_axis_tdata, if1.m_eth_payload_axis_tlast,
                            if1.m_eth_payload_axis_tuser, busy1, done1, tsv1, if1.m_eth_dest_mac}, '0);
        chk("t6_rst_frames", frames1, 32'd0);
        chk("t6_rst_ts_out", ts_out1, 96'd0);
        rst = 1'b0;
        set_cfg(16'd0, 16'd1, 32'd0, PAT_INC, 8'h33, 1'b1);
        clear_mon();
        pulse_start();
        wait_done(100, "t6");
        chk("t6_n1", q1.size(), 1);
        if (q1.size() == 1) begin
            chk("t6_tlast", ql[0], 1'b1);
            chk("t6_tuser", qu[0], 1'b1);
            chk("t6_byte0", q0[0], 8'h33);
        end
        chk("t6_frames", frames1, 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
